udp_txbuf_arb: RTL and testbench
================================

UDP_TXBUF_ARB -- requirements
Module: udp_txbuf_arb

Interface
REQ-001 Parameter: AWIDTH, default `UDP_TXBUF_AWIDTH, width of the UDP TX buffer address.
REQ-002 Ports: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
REQ-003 Core-side ports (connect to ros2_ether udp_txbuf_*):
- udp_txbuf_grant  in  1  core has handed the TX buffer to the application side.
- udp_txbuf_rel  out  1  one-cycle pulse handing the filled buffer to the core.
- udp_txbuf_addr  in  AWIDTH  core read address.
- udp_txbuf_ce  in  1  core read enable.
- udp_txbuf_rdata  out  32  muxed read data.
REQ-004 Requester ports, for i in {0,1}:
- req_i  in  1  level; requester i wants to send one datagram.
- grant_i  out  1  requester i owns the buffer.
- rel_i  in  1  pulse; requester i has finished with the buffer.
- addr_i  out  AWIDTH  read address seen by requester i.
- ce_i  out  1  read enable for requester i.
- rdata_i  in  32  requester i's buffer data.

Function
REQ-005 FSM states: IDLE, OWN, DRAIN; register sel (1 bit) and last (1 bit).
REQ-006 IDLE: when udp_txbuf_grant=1 and (req_0|req_1), load sel per REQ-012 and go to OWN on the next edge; otherwise stay in IDLE.
REQ-007 OWN: grant_sel = udp_txbuf_grant (combinational AND with the state); the non-selected grant = 0.
REQ-008 OWN, rel_sel=1 with udp_txbuf_grant=1: go to DRAIN, pulse udp_txbuf_rel for exactly one cycle on the following cycle, and set last<=sel.
REQ-009 OWN, req_sel=0 with rel_sel=0: abandon; go to IDLE with no udp_txbuf_rel and last unchanged.
REQ-010 DRAIN: sel is held. Wait for udp_txbuf_grant=0 (at least one cycle), then udp_txbuf_grant=1, then go to IDLE. A grant that stays high, or that is low on entry, still requires an observed low-then-high sequence.
REQ-011 udp_txbuf_rdata = rdata_sel, combinational (zero added latency). addr_0 = addr_1 = udp_txbuf_addr. ce_i = udp_txbuf_ce when state is DRAIN and sel=i; otherwise ce_i = 0.
REQ-012 Selection: round-robin. If both requesters request, pick ~last; if one requests, pick that one.
REQ-013 The following are ignored (no state change, no pulse):
- rel_i from a non-owner.
- rel_i in IDLE or DRAIN.
- rel_i while udp_txbuf_grant=0.
REQ-014 A simultaneous req change and rel_sel in OWN: rel_sel takes precedence (REQ-008).
REQ-015 grant_0 and grant_1 are never high in the same cycle.
REQ-016 udp_txbuf_rel is never high in two consecutive cycles.

Reset
REQ-017 On rst_n=0, asynchronously:
- state=IDLE, sel=0, last=1 (requester 0 wins the first tie).
- udp_txbuf_rel=0.
- grant_0=grant_1=0 and ce_0=ce_1=0.
REQ-018 Reset asserted mid-OWN or mid-DRAIN aborts the transfer; no udp_txbuf_rel is issued after reset release until a new REQ-008 event.

Configuration
REQ-019 Macro UDP_TXBUF_ARB_FIXED_PRIO_EN:
- Defined: REQ-012 is replaced by fixed priority; req_0 always wins, and last is not used for selection.
- Undefined: round-robin per REQ-012.

Verification
REQ-020 Single requester: grant=1, req_0=1 -> grant_0=1 within 1 cycle; rel_0 pulse -> udp_txbuf_rel=1 for exactly 1 cycle, 1 cycle later; grant_0=0.
REQ-021 Mux: in DRAIN with sel=1, udp_txbuf_addr=2, ce=1, rdata_1=32'h00000007 -> udp_txbuf_rdata=32'h00000007 in the same cycle, ce_1=1, ce_0=0.
REQ-022 Contention: req_0=req_1=1 held across 4 transfers -> grant order 0,1,0,1 (macro undefined) or 0,0,0,0 (macro defined).
REQ-023 Abandon: in OWN with sel=0, drop req_0 -> IDLE next cycle, no udp_txbuf_rel; a pending req_1 is granted next.
REQ-024 Robustness: rel_1 pulsed while requester 0 owns -> no effect. Assert rst_n=0 during DRAIN -> all outputs 0 immediately; after release, no spurious rel.

Source files
------------

// File: rtl/udp_txbuf_arb.sv
// Two-requester arbiter sharing the ros2_ether UDP TX buffer handshake; round-robin by default.
// Build option: define UDP_TXBUF_ARB_FIXED_PRIO_EN for fixed priority (req_0 always wins).
`ifndef UDP_TXBUF_AWIDTH
`define UDP_TXBUF_AWIDTH 11
`endif

module udp_txbuf_arb #(
  parameter int AWIDTH = `UDP_TXBUF_AWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              udp_txbuf_grant,
  output logic              udp_txbuf_rel,
  input  logic [AWIDTH-1:0] udp_txbuf_addr,
  input  logic              udp_txbuf_ce,
  output logic [31:0]       udp_txbuf_rdata,
  input  logic              req_0,
  output logic              grant_0,
  input  logic              rel_0,
  output logic [AWIDTH-1:0] addr_0,
  output logic              ce_0,
  input  logic [31:0]       rdata_0,
  input  logic              req_1,
  output logic              grant_1,
  input  logic              rel_1,
  output logic [AWIDTH-1:0] addr_1,
  output logic              ce_1,
  input  logic [31:0]       rdata_1
);

  typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_t;

  state_t state;
  logic   sel;
  logic   last;
  logic   low_seen;
  logic   rel_q;
  logic   req_sel;
  logic   rel_sel;
  logic   pick;

  assign req_sel = sel ? req_1 : req_0;
  assign rel_sel = sel ? rel_1 : rel_0;

  always_comb begin
    pick = 1'b0;
`ifdef UDP_TXBUF_ARB_FIXED_PRIO_EN
    pick = ~req_0;
`else
    if (req_0 && req_1) pick = ~last;
    else                pick = req_1;
`endif
  end

  // DRAIN only exits after a low-then-high grant, so rel_q can never fire twice back to back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= 1'b0;
      last     <= 1'b1;
      low_seen <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      rel_q <= 1'b0;
      case (state)
        IDLE: begin
          if (udp_txbuf_grant && (req_0 || req_1)) begin
            sel   <= pick;
            state <= OWN;
          end
        end
        OWN: begin
          if (rel_sel && udp_txbuf_grant) begin
            state    <= DRAIN;
            rel_q    <= 1'b1;
            last     <= sel;
            low_seen <= 1'b0;
          end else if (!req_sel && !rel_sel) begin
            state <= IDLE;
          end
        end
        DRAIN: begin
          if (!udp_txbuf_grant) low_seen <= 1'b1;
          else if (low_seen)    state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign udp_txbuf_rel   = rel_q;
  assign grant_0         = (state == OWN) && !sel && udp_txbuf_grant;
  assign grant_1         = (state == OWN) &&  sel && udp_txbuf_grant;
  assign ce_0            = (state == DRAIN) && !sel && udp_txbuf_ce;
  assign ce_1            = (state == DRAIN) &&  sel && udp_txbuf_ce;
  assign addr_0          = udp_txbuf_addr;
  assign addr_1          = udp_txbuf_addr;
  assign udp_txbuf_rdata = sel ? rdata_1 : rdata_0;

endmodule

// File: tb/tb_udp_txbuf_arb.sv
// Randomised bench for udp_txbuf_arb against a transaction-level ownership model.
module tb_udp_txbuf_arb;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          udp_txbuf_grant = 1'b0;
  logic          udp_txbuf_rel;
  logic [AW-1:0] udp_txbuf_addr = '0;
  logic          udp_txbuf_ce = 1'b0;
  logic [31:0]   udp_txbuf_rdata;
  logic          req_0 = 1'b0, rel_0 = 1'b0, grant_0, ce_0;
  logic          req_1 = 1'b0, rel_1 = 1'b0, grant_1, ce_1;
  logic [AW-1:0] addr_0, addr_1;
  logic [31:0]   rdata_0 = '0, rdata_1 = '0;

  always #5 clk = ~clk;

  udp_txbuf_arb #(.AWIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .udp_txbuf_grant(udp_txbuf_grant), .udp_txbuf_rel(udp_txbuf_rel),
    .udp_txbuf_addr(udp_txbuf_addr), .udp_txbuf_ce(udp_txbuf_ce),
    .udp_txbuf_rdata(udp_txbuf_rdata),
    .req_0(req_0), .grant_0(grant_0), .rel_0(rel_0), .addr_0(addr_0),
    .ce_0(ce_0), .rdata_0(rdata_0),
    .req_1(req_1), .grant_1(grant_1), .rel_1(rel_1), .addr_1(addr_1),
    .ce_1(ce_1), .rdata_1(rdata_1)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: who holds the buffer (0 none, 1 owning, 2 handed back), who owned it last.
  int m_mode, m_owner, m_last;
  bit m_low, m_rel, prev_rel;
  bit obs_g0, obs_g1;
  int exp_order[4];

  function automatic int winner();
`ifdef UDP_TXBUF_ARB_FIXED_PRIO_EN
    return req_0 ? 0 : 1;
`else
    if (req_0 && req_1) return 1 - m_last;
    return req_1 ? 1 : 0;
`endif
  endfunction

  task automatic model_reset();
    m_mode = 0; m_owner = 0; m_last = 1; m_low = 0; m_rel = 0; prev_rel = 0;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    bit own_rel, own_req, nxt_rel;
    #1;
    chk("grant_0", grant_0, (m_mode == 1 && m_owner == 0 && udp_txbuf_grant));
    chk("grant_1", grant_1, (m_mode == 1 && m_owner == 1 && udp_txbuf_grant));
    chk("ce_0", ce_0, (m_mode == 2 && m_owner == 0 && udp_txbuf_ce));
    chk("ce_1", ce_1, (m_mode == 2 && m_owner == 1 && udp_txbuf_ce));
    chk("rel", udp_txbuf_rel, m_rel);
    chk("rel_twice", udp_txbuf_rel & prev_rel, 0);
    chk("rdata", udp_txbuf_rdata, (m_owner == 1) ? rdata_1 : rdata_0);
    chk("addr_0", addr_0, udp_txbuf_addr);
    chk("addr_1", addr_1, udp_txbuf_addr);
    obs_g0 = grant_0;
    obs_g1 = grant_1;
    prev_rel = udp_txbuf_rel;
    nxt_rel = 0;
    own_rel = (m_owner == 1) ? rel_1 : rel_0;
    own_req = (m_owner == 1) ? req_1 : req_0;
    case (m_mode)
      0: if (udp_txbuf_grant && (req_0 || req_1)) begin
           m_owner = winner();
           m_mode = 1;
         end
      1: if (own_rel && udp_txbuf_grant) begin
           m_mode = 2; nxt_rel = 1; m_last = m_owner; m_low = 0;
         end else if (!own_req && !own_rel) begin
           m_mode = 0;
         end
      default: if (!udp_txbuf_grant) m_low = 1;
               else if (m_low) m_mode = 0;
    endcase
    m_rel = nxt_rel;
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_grant_0", grant_0, 0);
    chk("rst_grant_1", grant_1, 0);
    chk("rst_ce_0", ce_0, 0);
    chk("rst_ce_1", ce_1, 0);
    chk("rst_rel", udp_txbuf_rel, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int who;
`ifdef UDP_TXBUF_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    model_reset();
    repeat (2) @(negedge clk);
    chk("init_grant", {grant_0, grant_1}, 0);
    chk("init_ce", {ce_0, ce_1}, 0);
    chk("init_rel", udp_txbuf_rel, 0);
    rst_n = 1'b1;

    // Contention: both requesters held across four transfers.
    udp_txbuf_grant = 1; req_0 = 1; req_1 = 1;
    for (int k = 0; k < 4; k++) begin
      who = -1;
      for (int w = 0; w < 8 && who < 0; w++) begin
        step();
        if (obs_g0) who = 0;
        else if (obs_g1) who = 1;
      end
      if (who < 0) chk("order_timeout", 0, 1);
      chk("order", who, exp_order[k]);
      if (who == 1) rel_1 = 1; else rel_0 = 1;
      step();
      rel_0 = 0; rel_1 = 0; udp_txbuf_grant = 0;
      step();
      udp_txbuf_grant = 1;
      step();
    end

    // Single requester: grant, release pulse timing, then reset inside DRAIN.
    do_reset();
    req_1 = 0; req_0 = 1; udp_txbuf_grant = 1;
    step();
    #1 chk("single_grant", grant_0, 1);
    rel_0 = 1;
    step();
    rel_0 = 0;
    #1 chk("single_rel", udp_txbuf_rel, 1);
    chk("single_grant_off", grant_0, 0);
    step();
    #1 chk("single_rel_once", udp_txbuf_rel, 0);
    udp_txbuf_ce = 1;
    step();
    do_reset();
    req_0 = 0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("post_rst_norel", udp_txbuf_rel, 0);
      step();
    end

    // Read mux while requester 1 drains.
    req_1 = 1;
    step();
    rel_1 = 1;
    step();
    rel_1 = 0; udp_txbuf_addr = 2; udp_txbuf_ce = 1;
    rdata_1 = 32'h0000_0007; rdata_0 = 32'hdead_beef;
    #1 chk("mux_rdata", udp_txbuf_rdata, 32'h0000_0007);
    chk("mux_ce_1", ce_1, 1);
    chk("mux_ce_0", ce_0, 0);
    step();

    // Abandon with a stray release from the non-owner.
    do_reset();
    udp_txbuf_ce = 0; req_0 = 1; req_1 = 1;
    step();
    rel_1 = 1;
    #1 chk("own_g0", grant_0, 1);
    step();
    rel_1 = 0;
    #1 chk("stray_rel_g0", grant_0, 1);
    chk("stray_rel_out", udp_txbuf_rel, 0);
    req_0 = 0;
    step();
    #1 chk("abandon_idle", {grant_0, grant_1}, 0);
    chk("abandon_norel", udp_txbuf_rel, 0);
    step();
    #1 chk("abandon_next_g1", grant_1, 1);
    step();

    // Random traffic.
    repeat (3000) begin
      udp_txbuf_grant = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 7) == 0) req_0 = ~req_0;
      if ($urandom_range(0, 7) == 0) req_1 = ~req_1;
      rel_0 = ($urandom_range(0, 3) == 0);
      rel_1 = ($urandom_range(0, 3) == 0);
      udp_txbuf_ce = $urandom_range(0, 1);
      udp_txbuf_addr = AW'($urandom);
      rdata_0 = $urandom;
      rdata_1 = $urandom;
      if ($urandom_range(0, 499) == 0) do_reset();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
